// File: rtl/rcu_age_pkg.sv
// Shared sizes and types for the age-ordered requester ring.
// Holds the pointer and slot typedefs used by age_ring_requester and age_ring_reclaim.
package rcu_age_pkg;

    localparam int AGE_DEPTH        = 8;
    localparam int AGE_PTR_WIDTH    = 3;
    localparam int AGE_TAG_WIDTH    = 6;
    localparam int AGE_STARVE_LIMIT = 16;

    typedef struct packed {
        logic                     wrap;
        logic [AGE_PTR_WIDTH-1:0] idx;
    } age_ptr_t;

    typedef struct packed {
        logic                     valid;
        logic                     rdy;
        logic [AGE_TAG_WIDTH-1:0] tag;
    } age_slot_t;

    // The wrap bit rides along as the carry out of idx.
    function automatic age_ptr_t ptr_add(input age_ptr_t p, input logic [1:0] n);
        logic [AGE_PTR_WIDTH:0] sum;
        sum = {p.wrap, p.idx} + {{(AGE_PTR_WIDTH-1){1'b0}}, n};
        return age_ptr_t'(sum);
    endfunction

endpackage

// File: rtl/age_ring_reclaim.sv
// Counts how many dead slots (0..2) the head can step over this cycle.
// Looks at the post-grant valid vector so a slot granted this cycle frees immediately.
module age_ring_reclaim
    import rcu_age_pkg::*;
#(
    parameter int DEPTH     = AGE_DEPTH,
    parameter int PTR_WIDTH = AGE_PTR_WIDTH
) (
    input  logic [PTR_WIDTH-1:0] head_idx,
    input  logic [PTR_WIDTH:0]   occupancy,
    input  logic [DEPTH-1:0]     valid_pg,
    output logic [1:0]           reclaim_cnt
);

    logic [PTR_WIDTH-1:0] next_idx;

    assign next_idx = head_idx + PTR_WIDTH'(1);

    // The second step is only taken when the first one was, keeping reclaim in age order.
    always_comb begin
        reclaim_cnt = 2'd0;
        if (occupancy != '0 && !valid_pg[head_idx]) begin
            reclaim_cnt = 2'd1;
            if (occupancy > (PTR_WIDTH+1)'(1) && !valid_pg[next_idx]) begin
                reclaim_cnt = 2'd2;
            end
        end
    end

endmodule

// File: rtl/age_ring_requester.sv
// Requester side of the oldest-2 arbiter: circular age-ordered slot buffer feeding req/priority.
// Optional head-starvation detector enabled by defining AGE_RING_STARVE_EN.
module age_ring_requester
    import rcu_age_pkg::*;
#(
    parameter int DEPTH        = AGE_DEPTH,
    parameter int PTR_WIDTH    = AGE_PTR_WIDTH,
    parameter int TAG_WIDTH    = AGE_TAG_WIDTH
`ifdef AGE_RING_STARVE_EN
    ,
    parameter int STARVE_LIMIT = AGE_STARVE_LIMIT
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 alloc_valid_i,
    input  logic                 alloc_rdy_i,
    input  logic [TAG_WIDTH-1:0] alloc_tag_i,
    output logic                 alloc_ready_o,
    output logic [PTR_WIDTH-1:0] alloc_idx_o,
    input  logic                 wake_valid_i,
    input  logic [PTR_WIDTH-1:0] wake_idx_i,
    output logic [DEPTH-1:0]     req_o,
    output logic [PTR_WIDTH-1:0] priority_fix_o,
    input  logic                 first_grant_valid_i,
    input  logic [PTR_WIDTH-1:0] first_grant_index_i,
    input  logic                 second_grant_valid_i,
    input  logic [PTR_WIDTH-1:0] second_grant_index_i,
    output logic [TAG_WIDTH-1:0] first_tag_o,
    output logic [TAG_WIDTH-1:0] second_tag_o,
    output logic [PTR_WIDTH:0]   count_o,
    output logic                 empty_o,
    output logic                 starve_o
);

    age_ptr_t             head_q, tail_q, head_d, tail_d;
    logic [DEPTH-1:0]     valid_q, rdy_q, valid_d, rdy_d;
    logic [DEPTH-1:0]     grant_mask, valid_pg;
    logic [TAG_WIDTH-1:0] tag_q [DEPTH];
    logic [PTR_WIDTH:0]   count;
    logic [1:0]           reclaim_cnt;
    logic                 full, alloc_fire, wake_fire;
    age_slot_t            new_slot;

    assign count   = {tail_q.wrap, tail_q.idx} - {head_q.wrap, head_q.idx};
    assign full    = (head_q.idx == tail_q.idx) && (head_q.wrap != tail_q.wrap);

    assign alloc_ready_o  = !full;
    assign alloc_idx_o    = tail_q.idx;
    assign req_o          = valid_q & rdy_q;
    assign priority_fix_o = head_q.idx;
    assign count_o        = count;
    assign empty_o        = (count == '0);
    assign first_tag_o    = tag_q[first_grant_index_i];
    assign second_tag_o   = tag_q[second_grant_index_i];

    assign alloc_fire = alloc_valid_i && !full && !flush_i;
    assign new_slot   = '{valid: 1'b1, rdy: alloc_rdy_i, tag: alloc_tag_i};

    // A wake racing the alloc of the same slot would target the slot's previous life.
    assign wake_fire = wake_valid_i && valid_q[wake_idx_i]
                       && !(alloc_fire && (wake_idx_i == tail_q.idx));

    always_comb begin
        grant_mask = '0;
        if (first_grant_valid_i && req_o[first_grant_index_i]) begin
            grant_mask[first_grant_index_i] = 1'b1;
        end
        if (second_grant_valid_i && req_o[second_grant_index_i]) begin
            grant_mask[second_grant_index_i] = 1'b1;
        end
    end

    assign valid_pg = valid_q & ~grant_mask;

    age_ring_reclaim #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_reclaim (
        .head_idx    (head_q.idx),
        .occupancy   (count),
        .valid_pg    (valid_pg),
        .reclaim_cnt (reclaim_cnt)
    );

    always_comb begin
        valid_d = valid_pg;
        rdy_d   = rdy_q;
        if (wake_fire) begin
            rdy_d[wake_idx_i] = 1'b1;
        end
        rdy_d = rdy_d & ~grant_mask;
        if (alloc_fire) begin
            valid_d[tail_q.idx] = new_slot.valid;
            rdy_d[tail_q.idx]   = new_slot.rdy;
        end
        head_d = ptr_add(head_q, reclaim_cnt);
        tail_d = ptr_add(tail_q, {1'b0, alloc_fire});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            rdy_q   <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            rdy_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            rdy_q   <= rdy_d;
        end
    end

    // Tags are payload only; a slot's tag is meaningless until its valid bit is set.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            tag_q[tail_q.idx] <= new_slot.tag;
        end
    end

`ifdef AGE_RING_STARVE_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_cnt;
    logic                head_grant;

    assign head_grant = grant_mask[head_q.idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (flush_i || reclaim_cnt != 2'd0 || head_grant) begin
            starve_cnt <= '0;
        end else if (req_o[head_q.idx] && starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

    assign starve_o = (starve_cnt == STARVE_W'(STARVE_LIMIT));
`else
    assign starve_o = 1'b0;
`endif

    // Grants must target requesting slots and must not collide; the RTL tolerates both.
    a_grant0_req : assert property (@(posedge clk) disable iff (rst)
        (first_grant_valid_i && !flush_i) |-> req_o[first_grant_index_i]);
    a_grant1_req : assert property (@(posedge clk) disable iff (rst)
        (second_grant_valid_i && !flush_i) |-> req_o[second_grant_index_i]);
    a_grant_dup  : assert property (@(posedge clk) disable iff (rst)
        (first_grant_valid_i && second_grant_valid_i && !flush_i)
        |-> (first_grant_index_i != second_grant_index_i));

endmodule

// File: tb/tb_age_ring_requester.sv
// Directed bench for age_ring_requester; expectations queue up with each step and drain after the edge.
// Starvation expectations follow AGE_RING_STARVE_EN.
module tb_age_ring_requester;
    import rcu_age_pkg::*;

    localparam int DEPTH = AGE_DEPTH;
    localparam int PW    = AGE_PTR_WIDTH;
    localparam int TW    = AGE_TAG_WIDTH;
`ifdef AGE_RING_STARVE_EN
    localparam int STARVE_EXP = 1;
`else
    localparam int STARVE_EXP = 0;
`endif

    logic          clk, rst, flush_i;
    logic          alloc_valid_i, alloc_rdy_i;
    logic [TW-1:0] alloc_tag_i;
    logic          alloc_ready_o;
    logic [PW-1:0] alloc_idx_o;
    logic          wake_valid_i;
    logic [PW-1:0] wake_idx_i;
    logic [DEPTH-1:0] req_o;
    logic [PW-1:0] priority_fix_o;
    logic          first_grant_valid_i, second_grant_valid_i;
    logic [PW-1:0] first_grant_index_i, second_grant_index_i;
    logic [TW-1:0] first_tag_o, second_tag_o;
    logic [PW:0]   count_o;
    logic          empty_o, starve_o;

    age_ring_requester dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush_i              (flush_i),
        .alloc_valid_i        (alloc_valid_i),
        .alloc_rdy_i          (alloc_rdy_i),
        .alloc_tag_i          (alloc_tag_i),
        .alloc_ready_o        (alloc_ready_o),
        .alloc_idx_o          (alloc_idx_o),
        .wake_valid_i         (wake_valid_i),
        .wake_idx_i           (wake_idx_i),
        .req_o                (req_o),
        .priority_fix_o       (priority_fix_o),
        .first_grant_valid_i  (first_grant_valid_i),
        .first_grant_index_i  (first_grant_index_i),
        .second_grant_valid_i (second_grant_valid_i),
        .second_grant_index_i (second_grant_index_i),
        .first_tag_o          (first_tag_o),
        .second_tag_o         (second_tag_o),
        .count_o              (count_o),
        .empty_o              (empty_o),
        .starve_o             (starve_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {K_REQ, K_PRIO, K_COUNT, K_EMPTY, K_READY, K_IDX, K_STARVE, K_TAG0, K_TAG1} kind_t;
    typedef struct {
        string       name;
        kind_t       kind;
        int unsigned exp;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic int unsigned observe(input kind_t k);
        case (k)
            K_REQ:    return 32'(req_o);
            K_PRIO:   return 32'(priority_fix_o);
            K_COUNT:  return 32'(count_o);
            K_EMPTY:  return 32'(empty_o);
            K_READY:  return 32'(alloc_ready_o);
            K_IDX:    return 32'(alloc_idx_o);
            K_STARVE: return 32'(starve_o);
            K_TAG0:   return 32'(first_tag_o);
            default:  return 32'(second_tag_o);
        endcase
    endfunction

    task automatic expect_val(input string name, input kind_t k, input int unsigned e);
        exp_t x;
        x.name = name;
        x.kind = k;
        x.exp  = e;
        sb.push_back(x);
    endtask

    task automatic check_all();
        exp_t        x;
        int unsigned obs;
        while (sb.size() > 0) begin
            x   = sb.pop_front();
            obs = observe(x.kind);
            n_assert++;
            assert (obs === x.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", x.name, obs, x.exp);
            end
        end
    endtask

    task automatic idle();
        flush_i              = 1'b0;
        alloc_valid_i        = 1'b0;
        alloc_rdy_i          = 1'b0;
        alloc_tag_i          = '0;
        wake_valid_i         = 1'b0;
        wake_idx_i           = '0;
        first_grant_valid_i  = 1'b0;
        first_grant_index_i  = '0;
        second_grant_valid_i = 1'b0;
        second_grant_index_i = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        check_all();
        idle();
    endtask

    task automatic alloc(input int tag, input logic rdy);
        alloc_valid_i = 1'b1;
        alloc_rdy_i   = rdy;
        alloc_tag_i   = TW'(tag);
    endtask

    task automatic grant0(input int idx);
        first_grant_valid_i = 1'b1;
        first_grant_index_i = PW'(idx);
    endtask

    task automatic grant1(input int idx);
        second_grant_valid_i = 1'b1;
        second_grant_index_i = PW'(idx);
    endtask

    task automatic wake(input int idx);
        wake_valid_i = 1'b1;
        wake_idx_i   = PW'(idx);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        expect_val("rst_count", K_COUNT, 0);
        expect_val("rst_empty", K_EMPTY, 1);
        expect_val("rst_ready", K_READY, 1);
        expect_val("rst_req", K_REQ, 0);
        expect_val("rst_prio", K_PRIO, 0);
        expect_val("rst_starve", K_STARVE, 0);
        expect_val("rst_idx", K_IDX, 0);
        check_all();

        // fill all eight slots, eligible at once
        for (int i = 0; i < DEPTH; i++) begin
            alloc(i + 1, 1'b1);
            expect_val("fill_idx", K_IDX, i);
            expect_val("fill_ready", K_READY, 1);
            check_all();
            if (i == DEPTH - 1) begin
                expect_val("full_ready", K_READY, 0);
                expect_val("full_req", K_REQ, 8'hFF);
                expect_val("full_count", K_COUNT, 8);
                expect_val("full_empty", K_EMPTY, 0);
            end
            cycle();
        end
        first_grant_index_i  = 3'd3;
        second_grant_index_i = 3'd6;
        expect_val("tag_slot3", K_TAG0, 4);
        expect_val("tag_slot6", K_TAG1, 7);
        check_all();
        idle();

        // head pair granted together
        grant0(0);
        grant1(1);
        expect_val("g01_tag0", K_TAG0, 1);
        expect_val("g01_tag1", K_TAG1, 2);
        check_all();
        expect_val("g01_prio", K_PRIO, 2);
        expect_val("g01_count", K_COUNT, 6);
        expect_val("g01_ready", K_READY, 1);
        expect_val("g01_req", K_REQ, 8'hFC);
        cycle();

        // refill from a clean ring with tags 11..18
        flush_i = 1'b1;
        expect_val("reflush_count", K_COUNT, 0);
        cycle();
        for (int i = 0; i < DEPTH; i++) begin
            alloc(11 + i, 1'b1);
            cycle();
        end

        // holes behind a live head
        grant0(3);
        grant1(5);
        expect_val("hole_tag0", K_TAG0, 14);
        expect_val("hole_tag1", K_TAG1, 16);
        check_all();
        expect_val("hole_prio", K_PRIO, 0);
        expect_val("hole_count", K_COUNT, 8);
        expect_val("hole_req", K_REQ, 8'hD7);
        expect_val("hole_ready", K_READY, 0);
        cycle();
        grant0(0);
        expect_val("r0_prio", K_PRIO, 1);
        expect_val("r0_count", K_COUNT, 7);
        expect_val("r0_req", K_REQ, 8'hD6);
        expect_val("r0_ready", K_READY, 1);
        cycle();
        grant0(1);
        expect_val("r1_prio", K_PRIO, 2);
        expect_val("r1_count", K_COUNT, 6);
        cycle();
        grant0(2);
        expect_val("r2_prio", K_PRIO, 4);
        expect_val("r2_count", K_COUNT, 4);
        expect_val("r2_req", K_REQ, 8'hD0);
        cycle();
        expect_val("r_idle_prio", K_PRIO, 4);
        expect_val("r_idle_count", K_COUNT, 4);
        cycle();
        grant0(4);
        expect_val("r4_prio", K_PRIO, 6);
        expect_val("r4_count", K_COUNT, 2);
        expect_val("r4_req", K_REQ, 8'hC0);
        cycle();

        // wrap: fill slots 0..5 so tail lands on head with the wrap bit set
        for (int i = 0; i < 6; i++) begin
            alloc(21 + i, 1'b1);
            cycle();
        end
        expect_val("wrap_full_count", K_COUNT, 8);
        expect_val("wrap_full_ready", K_READY, 0);
        expect_val("wrap_full_idx", K_IDX, 6);
        expect_val("wrap_full_prio", K_PRIO, 6);
        check_all();
        alloc(40, 1'b1);
        grant0(6);
        expect_val("wrapA_prio", K_PRIO, 7);
        expect_val("wrapA_count", K_COUNT, 7);
        expect_val("wrapA_ready", K_READY, 1);
        expect_val("wrapA_idx", K_IDX, 6);
        expect_val("wrapA_req", K_REQ, 8'hBF);
        cycle();
        alloc(27, 1'b1);
        expect_val("wrapB_prio", K_PRIO, 7);
        expect_val("wrapB_idx", K_IDX, 7);
        expect_val("wrapB_count", K_COUNT, 8);
        expect_val("wrapB_ready", K_READY, 0);
        expect_val("wrapB_req", K_REQ, 8'hFF);
        cycle();
        first_grant_index_i = 3'd6;
        expect_val("wrap_tag6", K_TAG0, 27);
        check_all();
        idle();

        // flush beats alloc and two pending grants
        flush_i = 1'b1;
        alloc(50, 1'b1);
        grant0(7);
        grant1(0);
        expect_val("fl_count", K_COUNT, 0);
        expect_val("fl_empty", K_EMPTY, 1);
        expect_val("fl_ready", K_READY, 1);
        expect_val("fl_req", K_REQ, 0);
        expect_val("fl_prio", K_PRIO, 0);
        expect_val("fl_idx", K_IDX, 0);
        expect_val("fl_starve", K_STARVE, 0);
        cycle();

        // late wake
        alloc(31, 1'b1);
        cycle();
        alloc(32, 1'b1);
        cycle();
        alloc(33, 1'b0);
        expect_val("wk_pre_req", K_REQ, 8'h03);
        expect_val("wk_pre_count", K_COUNT, 3);
        expect_val("wk_pre_idx", K_IDX, 3);
        cycle();
        wake(2);
        expect_val("wk2_req", K_REQ, 8'h07);
        cycle();
        wake(5);
        expect_val("wk_empty_req", K_REQ, 8'h07);
        expect_val("wk_empty_count", K_COUNT, 3);
        cycle();
        alloc(34, 1'b0);
        wake(3);
        expect_val("wk_same_req", K_REQ, 8'h07);
        expect_val("wk_same_count", K_COUNT, 4);
        expect_val("wk_same_idx", K_IDX, 4);
        cycle();
        wake(3);
        expect_val("wk3_req", K_REQ, 8'h0F);
        cycle();

        // alloc, two grants and two reclaims in one cycle
        alloc(35, 1'b1);
        grant0(0);
        grant1(1);
        expect_val("all_prio", K_PRIO, 2);
        expect_val("all_count", K_COUNT, 3);
        expect_val("all_req", K_REQ, 8'h1C);
        expect_val("all_idx", K_IDX, 5);
        cycle();

        // head requesting but never granted
        repeat (15) cycle();
        expect_val("starve_15", K_STARVE, 0);
        check_all();
        expect_val("starve_16", K_STARVE, STARVE_EXP);
        cycle();
        grant0(2);
        expect_val("starve_clr", K_STARVE, 0);
        expect_val("starve_clr_prio", K_PRIO, 3);
        expect_val("starve_clr_count", K_COUNT, 2);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
